// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU.
// Used by the stage-2 datapath and the pipeline wrapper.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ILL   = 4;
  localparam int NFLAGS     = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and status flags.
// Illegal opcodes yield a zero result with only the illegal flag set.
module alu_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [SHW-1:0]    Shiftamt,
  input  logic [3:0]        Sel,
  output logic [WIDTH-1:0]  result,
  output logic [NFLAGS-1:0] flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             carry;
  logic             ovf;
  logic             ill;
  logic             lts;
  logic             ltu;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  assign lts  = $signed(A) < $signed(B);
  assign ltu  = A < B;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    ill    = 1'b0;
    unique case (Sel)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (A[WIDTH-1] == B[WIDTH-1]) &&
                 (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        // diff's top bit is the borrow; carry reports no-borrow
        carry  = ~diff[WIDTH];
        ovf    = (A[WIDTH-1] != B[WIDTH-1]) &&
                 (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_AND:  result = A & B;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lts};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, ltu};
      OP_SLL:  result = A << Shiftamt;
      OP_SRL:  result = A >> Shiftamt;
      OP_SRA:  result = $signed(A) >>> Shiftamt;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    flags = '0;
    if (ill) begin
      flags[FLAG_ILL] = 1'b1;
    end else begin
      flags[FLAG_ZERO]  = (result == '0);
      flags[FLAG_NEG]   = result[WIDTH-1];
      flags[FLAG_CARRY] = carry;
      flags[FLAG_OVF]   = ovf;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 latches the request,
// stage 2 registers the computed result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [SHW-1:0]    Shiftamt,
  input  logic [3:0]        Sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Output,
  output logic [NFLAGS-1:0] flags
);

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic [SHW-1:0]    s1_sh;
  logic [3:0]        s1_sel;

  logic              adv2;
  logic [WIDTH-1:0]  core_res;
  logic [NFLAGS-1:0] core_flags;

  // in_ready depends only on pipeline state and out_ready
  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sh    <= '0;
      s1_sel   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_sh  <= Shiftamt;
        s1_sel <= Sel;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .A        (s1_a),
    .B        (s1_b),
    .Shiftamt (s1_sh),
    .Sel      (s1_sel),
    .result   (core_res),
    .flags    (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Output    <= '0;
      flags     <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Output <= core_res;
        flags  <= core_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: opcode vector table plus
// stall, ordering and mid-flight reset sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic [5:0]  Shiftamt;
  logic [3:0]  Sel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] Output;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Shiftamt  (Shiftamt),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Output    (Output),
    .flags     (flags)
  );

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sh;
    logic [63:0] exp_o;
    logic [4:0]  exp_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [3:0] s,
                              logic [63:0] a, logic [63:0] b,
                              logic [5:0] sh, logic [63:0] eo,
                              logic [4:0] ef);
    vec_t v;
    v.name = n; v.sel = s; v.a = a; v.b = b;
    v.sh = sh; v.exp_o = eo; v.exp_f = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // flags = {illegal, overflow, carry, negative, zero}
  task automatic run_one(input vec_t v);
    A = v.a; B = v.b; Shiftamt = v.sh; Sel = v.sel;
    in_valid = 1'b1;
    #1;
    chk({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({v.name, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({v.name, "_valid"}, 64'(out_valid), 64'd1);
    chk({v.name, "_out"}, Output, v.exp_o);
    chk({v.name, "_flags"}, 64'(flags), 64'(v.exp_f));
  endtask

  localparam logic [63:0] XA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] XB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t v;
    logic        acc, drn, prev_stall;
    logic [63:0] prev_out;
    int sent, recv, cyc;

    vecs.push_back(mk("add_aabb", OP_ADD, XA, XB, 6'd0,
                      64'h6666_6666_6666_6665, 5'b01100));
    vecs.push_back(mk("sub_aabb", OP_SUB, XA, XB, 6'd0,
                      64'hEEEE_EEEE_EEEE_EEEF, 5'b00010));
    vecs.push_back(mk("slt_aabb", OP_SLT, XA, XB, 6'd0, 64'd1, 5'b00000));
    vecs.push_back(mk("sltu_aabb", OP_SLTU, XA, XB, 6'd0, 64'd1, 5'b00000));
    vecs.push_back(mk("sll4", OP_SLL, XA, XB, 6'd4,
                      64'hAAAA_AAAA_AAAA_AAA0, 5'b00010));
    vecs.push_back(mk("srl4", OP_SRL, XA, XB, 6'd4,
                      64'h0AAA_AAAA_AAAA_AAAA, 5'b00000));
    vecs.push_back(mk("sra4", OP_SRA, XA, XB, 6'd4,
                      64'hFAAA_AAAA_AAAA_AAAA, 5'b00010));
    vecs.push_back(mk("illegal12", 4'd12, XA, XB, 6'd3, 64'd0, 5'b10000));
    vecs.push_back(mk("illegal15", 4'd15, ONES, 64'd1, 6'd0, 64'd0, 5'b10000));
    vecs.push_back(mk("xor_eq", OP_XOR, 64'h1234, 64'h1234, 6'd0,
                      64'd0, 5'b00001));
    vecs.push_back(mk("or", OP_OR, 64'hF0, 64'h0F, 6'd0, 64'hFF, 5'b00000));
    vecs.push_back(mk("and0", OP_AND, 64'hF0, 64'h0F, 6'd0, 64'd0, 5'b00001));
    vecs.push_back(mk("add_ovf", OP_ADD, MAXP, 64'd1, 6'd0, MINN, 5'b01010));
    vecs.push_back(mk("add_wrap", OP_ADD, ONES, 64'd1, 6'd0, 64'd0, 5'b00101));
    vecs.push_back(mk("sub_eq", OP_SUB, 64'd5, 64'd5, 6'd0, 64'd0, 5'b00101));
    vecs.push_back(mk("sub_ovf", OP_SUB, MINN, 64'd1, 6'd0, MAXP, 5'b01100));
    vecs.push_back(mk("sll0", OP_SLL, XA, XB, 6'd0, XA, 5'b00010));
    vecs.push_back(mk("slt_pos_neg", OP_SLT, 64'd1, ONES, 6'd0, 64'd0, 5'b00001));
    vecs.push_back(mk("sltu_pos_neg", OP_SLTU, 64'd1, ONES, 6'd0, 64'd1, 5'b00000));
    vecs.push_back(mk("sra63", OP_SRA, MINN, 64'd0, 6'd63, ONES, 5'b00010));
    vecs.push_back(mk("srl63", OP_SRL, MINN, 64'd0, 6'd63, 64'd1, 5'b00000));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Shiftamt = '0; Sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_output", Output, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_one(vecs[i]);

    // back-to-back stream with a consumer stall
    @(posedge clk); #1;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; prev_out = '0;
    while (recv < 10 && cyc < 60) begin
      in_valid = (sent < 10);
      A = 64'(sent); B = 64'd100; Shiftamt = '0; Sel = OP_ADD;
      out_ready = !(cyc >= 3 && cyc <= 7);
      #1;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_out", Output, prev_out);
      end
      if (sent - recv == 2 && !out_ready)
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (drn) begin
        chk("stream_order", Output, 64'(recv) + 64'd100);
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = Output;
      if (acc) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_count", 64'(recv), 64'd10);
    in_valid = 1'b0; out_ready = 1'b1;

    // reset with two requests in flight, and a request at the reset edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    Sel = OP_ADD; A = 64'd1; B = 64'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 64'd3; B = 64'd4;
    @(posedge clk); #1;
    A = 64'd9; B = 64'd9;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_output", Output, 64'd0);
    chk("midrst_flags", 64'(flags), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    v = mk("post_rst_add", OP_ADD, 64'd5, 64'd6, 6'd0, 64'd11, 5'b00000);
    run_one(v);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits, legal values 8, 16, 32, 64.
REQ-002 SHALL have localparam SHW = clog2(WIDTH): shift-amount width, 6 at default.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: request present on A/B/Shiftamt/Sel.
REQ-006 SHALL have port in_ready  output  1: request accepted on the edge where in_valid && in_ready.
REQ-007 SHALL have port A  input  WIDTH: operand A.
REQ-008 SHALL have port B  input  WIDTH: operand B.
REQ-009 SHALL have port Shiftamt  input  SHW: shift distance.
REQ-010 SHALL have port Sel  input  4: opcode, encoded per REQ-016.
REQ-011 SHALL have port out_valid  output  1: Output and flags hold a result.
REQ-012 SHALL have port out_ready  input  1: consumer takes result on out_valid && out_ready.
REQ-013 SHALL have port Output  output  WIDTH: result.
REQ-014 SHALL have port flags  output  5: {illegal, overflow, carry, negative, zero}.

Function
REQ-015 SHALL be a two-stage pipeline: stage 1 registers the request; stage 2 computes and registers Output/flags; accept-to-out_valid latency is exactly 2 cycles when unstalled.
REQ-016 SHALL decode Sel: 0 ADD, 1 SUB (A-B), 2 OR, 3 XOR, 4 AND, 5 SLT signed, 6 SLL A by Shiftamt, 7 SRL A, 8 SRA A, 9 SLTU; 10-15 illegal.
REQ-017 SHALL return 1 in bit 0 and zeros elsewhere for SLT/SLTU when A<B, else all zeros.
REQ-018 SHALL on illegal Sel drive Output = 0, set illegal=1, clear all other flags.
REQ-019 SHALL set zero = (Output==0), negative = Output[WIDTH-1] for all legal ops.
REQ-020 SHALL set carry = carry-out for ADD, = no-borrow (A>=B unsigned) for SUB, 0 for all other ops.
REQ-021 SHALL set overflow = signed two's-complement overflow for ADD/SUB, 0 for all other ops.
REQ-022 SHALL ignore B for shifts; shift of 0 returns A unchanged; SRA fills with A[WIDTH-1].
REQ-023 SHALL advance stage 2 when !out_valid || out_ready; stage 1 when stage 1 empty or stage 2 advances; in_ready = stage-1 empty || stage 2 advances (no combinational path from in_valid to in_ready).
REQ-024 SHALL sustain one accepted request per cycle while out_ready=1.
REQ-025 SHALL hold Output, flags and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL, on a simultaneous accept and drain, neither drop nor duplicate a result; results leave in acceptance order.

Reset
REQ-027 SHALL on rst=1 at a rising edge clear both stage valids, Output=0, flags=0, out_valid=0; in_ready=1 the cycle after.
REQ-028 SHALL discard any in-flight request when reset asserts mid-operation; no result for it appears after reset.
REQ-029 SHALL treat rst as dominant over in_valid/out_ready in the same cycle.

Structure
REQ-030 SHALL place the opcode constants (OP_ADD..OP_SLTU) and flag bit indices in shared package alu_pkg.
REQ-031 SHALL implement the stage-2 datapath as combinational sub-module alu_core (A, B, Shiftamt, Sel -> result, flags) parametrised by WIDTH.

Verification (WIDTH=64, out_ready=1 unless stated)
REQ-032 SHALL cover ADD A=AAAA_AAAA_AAAA_AAAA, B=BBBB_BBBB_BBBB_BBBB -> Output=6666_6666_6666_6665, carry=1, overflow=1 (neg+neg=pos), out_valid 2 cycles after accept.
REQ-033 SHALL cover SUB same operands -> Output=EEEE_EEEE_EEEE_EEEF, carry=0, negative=1; SLT -> 1; SLTU -> 1.
REQ-034 SHALL cover Shiftamt=4, A=AAAA_AAAA_AAAA_AAAA: SLL -> AAAA_AAAA_AAAA_AAA0, SRL -> 0AAA_AAAA_AAAA_AAAA, SRA -> FAAA_AAAA_AAAA_AAAA.
REQ-035 SHALL cover back-to-back 10 requests with out_ready held 0 for cycles 3-7 -> all 10 results delivered in order, Output stable while stalled, in_ready=0 once both stages full.
REQ-036 SHALL cover Sel=12 -> Output=0, flags=5'b10000; XOR A=B -> Output=0, zero=1.
REQ-037 SHALL cover rst pulse one cycle after accepting two requests -> out_valid stays 0, no stale result emitted, next request completes with correct value.
